// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin arbiter that shares one free-running 32-bit random
// generator among NUM_REQ requesters. Each grant carries a value reduced to the
// requester's range [0, bound-1] by masked rejection sampling. A deterministic
// fold is used once MAX_TRIES samples have all been rejected.
module rand_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BOUND_W   = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BOUND_W-1:0] bound,
  input  logic [31:0]                rand_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [BOUND_W-1:0]         rnd_out,
  output logic                       rnd_valid,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Smallest all-ones mask covering [0, b-1]; ranges of size 0 or 1 need no bits.
  function automatic logic [BOUND_W-1:0] range_mask(input logic [BOUND_W-1:0] b);
    logic [BOUND_W-1:0] m;
    if (b <= BOUND_W'(1)) begin
      m = '0;
    end else begin
      m = b - BOUND_W'(1);
      for (int s = 1; s < BOUND_W; s = s * 2) begin
        m = m | (m >> s);
      end
    end
    return m;
  endfunction

  // Fallback reduction of a rejected in-mask candidate. Since the mask is below
  // 2*bound, cand - b always lands inside [0, b-1].
  function automatic logic [BOUND_W-1:0] fold(input logic [BOUND_W-1:0] cand,
                                              input logic [BOUND_W-1:0] b);
    return cand - b;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [TRY_W-1:0]   try_q;

  // Request context captured in the IDLE cycle that selects the requester.
  logic [IDX_W-1:0]   idx_p0;
  logic [BOUND_W-1:0] bound_p0;
  logic [BOUND_W-1:0] mask_p0;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [BOUND_W-1:0] sel_bound;

  logic [BOUND_W-1:0] cand;
  logic               small_range;
  logic               accept;
  logic               last_try;
  logic               finish;
  logic [BOUND_W-1:0] result;

  logic               unused_rand;
  assign unused_rand = ^rand_in[31:BOUND_W];

  // Round-robin pick: first requesting index at or after ptr, with wrap.
  always_comb begin
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_bound = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!sel_found && req[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
        sel_bound = bound[j*BOUND_W +: BOUND_W];
      end
    end
  end

  // Sample evaluation against the current generator output.
  always_comb begin
    cand        = rand_in[BOUND_W-1:0] & mask_p0;
    small_range = (bound_p0 <= BOUND_W'(1));
    accept      = small_range || (cand < bound_p0);
    last_try    = (try_q == TRY_W'(MAX_TRIES - 1));
    finish      = accept || last_try;
    if (small_range) begin
      result = '0;
    end else if (accept) begin
      result = cand;
    end else begin
      result = fold(cand, bound_p0);
    end
  end

  // State register and control counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      try_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_found) begin
        try_q <= '0;
      end else if (state_q == SAMPLE && !finish) begin
        try_q <= try_q + TRY_W'(1);
      end
      if (state_q == DONE) begin
        ptr_q <= (idx_p0 == IDX_W'(NUM_REQ - 1)) ? '0 : idx_p0 + IDX_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = SAMPLE;
      SAMPLE:  if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Latch the selected requester's index, bound and mask.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && sel_found) begin
      idx_p0   <= sel_idx;
      bound_p0 <= sel_bound;
      mask_p0  <= range_mask(sel_bound);
    end
  end

  // Registered grant outputs, loaded on the SAMPLE->DONE transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (state_q == SAMPLE && finish) begin
        gnt       <= NUM_REQ'(1) << idx_p0;
        rnd_valid <= 1'b1;
        rnd_out   <= result;
      end
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: a transaction-level model predicts the
// winner, result and grant cycle of each service; a monitor checks them.
module tb_rand_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BOUND_W   = 8;
  localparam int MAX_TRIES = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NUM_REQ-1:0]         req = '0;
  logic [NUM_REQ*BOUND_W-1:0] bound = '0;
  logic [31:0]                rand_in = '0;
  logic [NUM_REQ-1:0]         gnt;
  logic [BOUND_W-1:0]         rnd_out;
  logic                       rnd_valid;
  logic                       busy;

  rand_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .BOUND_W  (BOUND_W),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bound    (bound),
    .rand_in  (rand_in),
    .gnt      (gnt),
    .rnd_out  (rnd_out),
    .rnd_valid(rnd_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int res;
    int cyc;
    int bnd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mptr = 0;
  int          bnd_buf[NUM_REQ];
  logic [31:0] rv_buf[MAX_TRIES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", nm, got, want, cyc);
    end
  endtask

  task automatic drive_bounds();
    for (int i = 0; i < NUM_REQ; i++) bound[i*BOUND_W +: BOUND_W] = BOUND_W'(bnd_buf[i]);
  endtask

  // One service, called on a negedge while the DUT is in IDLE. The model picks
  // the winner by round robin and draws from rv_buf until a sample fits.
  task automatic serve(input logic [NUM_REQ-1:0] m, input logic [NUM_REQ-1:0] late_m,
                       input bit scramble);
    int w, n, res, b, p, msk, c;
    exp_t e;
    w = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (mptr + i) % NUM_REQ;
      if (w < 0 && m[j]) w = j;
    end
    b = bnd_buf[w];
    n = 1;
    res = 0;
    if (b > 1) begin
      p = 1;
      while (p < b) p = p * 2;
      msk = p - 1;
      res = -1;
      for (int k = 0; k < MAX_TRIES && res < 0; k++) begin
        c = int'(rv_buf[k][BOUND_W-1:0]) & msk;
        n = k + 1;
        if (c < b) res = c;
        else if (k == MAX_TRIES - 1) res = c - b;
      end
    end
    mptr = (w + 1) % NUM_REQ;
    e.idx = w; e.res = res; e.cyc = cyc + 1 + n; e.bnd = b;
    exp_q.push_back(e);
    req = m;
    drive_bounds();
    rand_in = rv_buf[0];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("busy_sample", {31'd0, busy}, 32'd1);
        req = m | late_m;
        if (scramble) begin
          for (int i = 0; i < NUM_REQ; i++) bnd_buf[i] = $urandom_range(0, 255);
          drive_bounds();
        end
      end
      rand_in = rv_buf[k];
    end
    @(negedge clk);
    rand_in = $urandom;
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rnd_out", {24'd0, rnd_out}, 32'd0);
    chk("rst_rnd_valid", {31'd0, rnd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    exp_q.delete();
    mptr = 0;
    rst = 1'b1;
  endtask

  function automatic int pick_bound();
    case ($urandom_range(0, 9))
      0: return 0;
      1: return 1;
      2: return 255;
      3: return 2;
      4: return 1 << $urandom_range(1, 7);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  // Monitor: every cycle the grant shape is checked; each result is scored.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("gnt_in_reset", {27'd0, gnt, rnd_valid}, 32'd0);
    end else if (rnd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, rnd_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("gnt", {28'd0, gnt}, 32'd1 << e.idx);
        chk("rnd_out", {24'd0, rnd_out}, e.res);
        chk("grant_cycle", cyc, e.cyc);
        chk("busy_done", {31'd0, busy}, 32'd1);
        if (e.bnd >= 2) chk("rnd_lt_bound", {31'd0, (int'(rnd_out) < e.bnd)}, 32'd1);
      end
    end else begin
      chk("gnt_quiet", {28'd0, gnt}, 32'd0);
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        chk("grant_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) bnd_buf[i] = 0;
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset pulled while sampling discards the service.
    req = 4'b0001;
    bnd_buf[0] = 5;
    drive_bounds();
    rand_in = 32'd7;
    repeat (2) @(negedge clk);
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    exp_q.delete();
    mptr = 0;
    rst = 1'b1;
    rv_buf = '{32'd3, 32'd3, 32'd3, 32'd3};
    serve(4'b0001, 4'b0000, 1'b0);

    // Rejections ending in the fold, then a rejection followed by an accept.
    bnd_buf[0] = 5;
    rv_buf = '{32'd6, 32'd7, 32'd5, 32'd6};
    serve(4'b0001, 4'b0000, 1'b0);
    rv_buf = '{32'd6, 32'd2, 32'd0, 32'd0};
    serve(4'b0001, 4'b0000, 1'b0);

    // Degenerate and full-width bounds.
    rv_buf = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bnd_buf[0] = 0;
    serve(4'b0001, 4'b0000, 1'b0);
    bnd_buf[0] = 1;
    serve(4'b0001, 4'b0000, 1'b0);
    bnd_buf[0] = 255;
    rv_buf = '{32'h123456FF, 32'hABCDEF10, 32'd0, 32'd0};
    serve(4'b0001, 4'b0000, 1'b0);

    // Round robin with all requesters held.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) bnd_buf[i] = 16;
    for (int s = 0; s < 5; s++) begin
      rv_buf = '{cyc, cyc + 1, cyc + 2, cyc + 3};
      serve(4'b1111, 4'b0000, 1'b0);
    end

    // Held request and a late arrival ranked by the pointer.
    bnd_buf[1] = 8;
    bnd_buf[2] = 8;
    rv_buf = '{32'd3, 32'd3, 32'd3, 32'd3};
    serve(4'b0100, 4'b0000, 1'b0);
    serve(4'b0100, 4'b0000, 1'b0);
    serve(4'b0100, 4'b0010, 1'b0);
    serve(4'b0110, 4'b0000, 1'b0);
    serve(4'b0100, 4'b0000, 1'b0);

    // Randomized services.
    for (int s = 0; s < 10000; s++) begin
      for (int i = 0; i < NUM_REQ; i++) bnd_buf[i] = pick_bound();
      for (int k = 0; k < MAX_TRIES; k++) rv_buf[k] = $urandom;
      serve(NUM_REQ'($urandom_range(1, 15)), NUM_REQ'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    req = '0;
    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
